pixel_row_assembler: RTL and testbench

- Serial-to-parallel front end of the image buffer. Collects a binary pixel stream one bit at a time into NrOfBits-wide row words.
- Drives the D / ClockEnable / Tick inputs of the downstream row register file, one register per row, selected through RowAddr.
- Sequences one full frame of NrOfRows rows, then signals frame completion to the recognition core.

---
 rtl/pixel_row_assembler_pkg.sv | 24 ++
 rtl/pixel_row_assembler_if.sv | 56 +++++
 rtl/pixel_row_assembler_collector.sv | 63 ++++++
 rtl/pixel_row_assembler.sv | 137 +++++++++++++
 tb/tb_pixel_row_assembler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_row_assembler_pkg.sv
// ---------------------------------------------------------------------------
// pixel_row_assembler_pkg
// Shared constants for the pixel row assembler: frame geometry defaults,
// FSM state encoding and a column-counter width helper.
// ---------------------------------------------------------------------------
package pixel_row_assembler_pkg;

   // Default frame geometry: 28x28 binary image, 5-bit row index.
   localparam int unsigned DEF_NR_OF_BITS     = 28;
   localparam int unsigned DEF_NR_OF_ROWS     = 28;
   localparam int unsigned DEF_ROW_ADDR_BITS  = 5;

   // FSM state encoding.
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] WRITE   = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   // Width of a counter that indexes 0..bits-1 (at least one bit).
   function automatic int unsigned col_width(input int unsigned bits);
      return (bits > 1) ? $clog2(bits) : 1;
   endfunction

endpackage : pixel_row_assembler_pkg

// File: rtl/pixel_row_assembler_if.sv
// ---------------------------------------------------------------------------
// pixel_row_assembler_if
// Pixel stream handshake plus row-register-file write port.
//   FrameStart  : begin / restart frame capture        (source -> assembler)
//   PixelValid  : PixelData is valid                   (source -> assembler)
//   PixelData   : pixel value, 1 = ink                 (source -> assembler)
//   PixelReady  : assembler accepts a pixel this cycle (assembler -> source)
//   RowData     : assembled row, downstream D          (assembler -> sink)
//   RowWe       : row write strobe, downstream CE      (assembler -> sink)
//   RowAddr     : index of the row being written       (assembler -> sink)
//   Busy        : frame capture in progress            (assembler -> sink)
//   FrameDone   : one-cycle frame-complete flag        (assembler -> sink)
// The master modport is the pixel source / observer, slave is the assembler.
// ---------------------------------------------------------------------------
interface pixel_row_assembler_if
   import pixel_row_assembler_pkg::*;
#(
   parameter int unsigned NrOfBits    = DEF_NR_OF_BITS,
   parameter int unsigned RowAddrBits = DEF_ROW_ADDR_BITS
) ();

   logic                   FrameStart;
   logic                   PixelValid;
   logic                   PixelData;
   logic                   PixelReady;
   logic [NrOfBits-1:0]    RowData;
   logic                   RowWe;
   logic [RowAddrBits-1:0] RowAddr;
   logic                   Busy;
   logic                   FrameDone;

   modport master (
      output FrameStart,
      output PixelValid,
      output PixelData,
      input  PixelReady,
      input  RowData,
      input  RowWe,
      input  RowAddr,
      input  Busy,
      input  FrameDone
   );

   modport slave (
      input  FrameStart,
      input  PixelValid,
      input  PixelData,
      output PixelReady,
      output RowData,
      output RowWe,
      output RowAddr,
      output Busy,
      output FrameDone
   );

endinterface : pixel_row_assembler_if

// File: rtl/pixel_row_assembler_collector.sv
// ---------------------------------------------------------------------------
// row_shift_collector
// Column counter plus NrOfBits-wide position register. Each loaded pixel is
// written at bit NrOfBits-1-col, so the first pixel of a row ends in the MSB.
//   clk, rst   : clock, asynchronous active-high reset
//   en         : global clock enable (Tick); nothing changes while low
//   clear      : zero row and column (wins over load)
//   load       : store pixel at the current column and advance
//   pixel      : pixel value
//   row_data   : assembled row (registered)
//   last_pixel : column counter sits on the last column (registered)
// ---------------------------------------------------------------------------
module row_shift_collector
   import pixel_row_assembler_pkg::*;
#(
   parameter int unsigned NrOfBits = DEF_NR_OF_BITS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                clear,
   input  logic                load,
   input  logic                pixel,
   output logic [NrOfBits-1:0] row_data,
   output logic                last_pixel
);

   localparam int unsigned ColW    = col_width(NrOfBits);
   localparam logic [ColW-1:0] LastCol = ColW'(NrOfBits - 1);
   // A one-column row is always on its last column.
   localparam logic        SingleCol = (NrOfBits == 1);

   logic [ColW-1:0] col;

   // Column counter and position register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col        <= '0;
         row_data   <= '0;
         last_pixel <= SingleCol;
      end else if (en) begin
         if (clear) begin
            col        <= '0;
            row_data   <= '0;
            last_pixel <= SingleCol;
         end else if (load) begin
            for (int unsigned i = 0; i < NrOfBits; i++) begin
               if (col == ColW'(NrOfBits - 1 - i)) begin
                  row_data[i] <= pixel;
               end
            end
            if (last_pixel) begin
               col        <= '0;
               last_pixel <= SingleCol;
            end else begin
               col        <= col + ColW'(1);
               last_pixel <= ((col + ColW'(1)) == LastCol);
            end
         end
      end
   end

endmodule : row_shift_collector

// File: rtl/pixel_row_assembler.sv
// ---------------------------------------------------------------------------
// pixel_row_assembler
// Serial-to-parallel front end of the image buffer: collects a binary pixel
// stream into NrOfBits-wide rows, writes each row into the downstream row
// register file (one register per row, selected by RowAddr) and flags frame
// completion after NrOfRows rows.
//   Clock : system clock, rising edge
//   Reset : asynchronous, active-high
//   Tick  : global clock enable; state advances only on Tick edges
//   bus   : pixel handshake and row write port (slave modport)
// ---------------------------------------------------------------------------
module pixel_row_assembler
   import pixel_row_assembler_pkg::*;
#(
   parameter int unsigned NrOfBits    = DEF_NR_OF_BITS,
   parameter int unsigned NrOfRows    = DEF_NR_OF_ROWS,
   parameter int unsigned RowAddrBits = DEF_ROW_ADDR_BITS
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  Tick,
   pixel_row_assembler_if.slave  bus
);

   localparam logic [RowAddrBits-1:0] LastRow = RowAddrBits'(NrOfRows - 1);

   logic [1:0]             state;
   logic [1:0]             next_state;
   logic [RowAddrBits-1:0] row_addr;
   logic [RowAddrBits-1:0] next_addr;

   logic                   pixel_ready;
   logic                   row_we;
   logic                   busy;
   logic                   frame_done;
   logic                   next_pixel_ready;
   logic                   next_row_we;
   logic                   next_busy;
   logic                   next_frame_done;

   logic                   clear_c;
   logic                   load_c;
   logic                   last_pixel;
   logic [NrOfBits-1:0]    row_data;

   // Row data path: column counter and position register.
   row_shift_collector #(
      .NrOfBits (NrOfBits)
   ) u_collector (
      .clk        (Clock),
      .rst        (Reset),
      .en         (Tick),
      .clear      (clear_c),
      .load       (load_c),
      .pixel      (bus.PixelData),
      .row_data   (row_data),
      .last_pixel (last_pixel)
   );

   // Next-state, row address and collector control.
   always_comb begin
      next_state = state;
      next_addr  = row_addr;
      clear_c    = 1'b0;
      load_c     = 1'b0;

      if (bus.FrameStart) begin
         // Start or abort: clean restart, any pixel offered now is dropped.
         next_state = COLLECT;
         next_addr  = '0;
         clear_c    = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               next_state = IDLE;
            end
            COLLECT: begin
               if (bus.PixelValid) begin
                  load_c = 1'b1;
                  if (last_pixel) begin
                     next_state = WRITE;
                  end
               end
            end
            WRITE: begin
               // RowWe is high for exactly this one Tick edge.
               if (row_addr == LastRow) begin
                  next_state = DONE;
               end else begin
                  next_state = COLLECT;
                  next_addr  = row_addr + RowAddrBits'(1);
                  clear_c    = 1'b1;
               end
            end
            DONE: begin
               next_state = IDLE;
            end
            default: begin
               next_state = IDLE;
            end
         endcase
      end

      // Moore outputs, registered alongside the state.
      next_pixel_ready = (next_state == COLLECT);
      next_row_we      = (next_state == WRITE);
      next_busy        = (next_state == COLLECT) || (next_state == WRITE);
      next_frame_done  = (next_state == DONE);
   end

   // State, row address and output registers.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         row_addr    <= '0;
         pixel_ready <= 1'b0;
         row_we      <= 1'b0;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
      end else if (Tick) begin
         state       <= next_state;
         row_addr    <= next_addr;
         pixel_ready <= next_pixel_ready;
         row_we      <= next_row_we;
         busy        <= next_busy;
         frame_done  <= next_frame_done;
      end
   end

   assign bus.PixelReady = pixel_ready;
   assign bus.RowData    = row_data;
   assign bus.RowWe      = row_we;
   assign bus.RowAddr    = row_addr;
   assign bus.Busy       = busy;
   assign bus.FrameDone  = frame_done;

endmodule : pixel_row_assembler

// File: tb/tb_pixel_row_assembler.sv
// ---------------------------------------------------------------------------
// tb_pixel_row_assembler
// Directed, table-driven bench for pixel_row_assembler with a 4-pixel,
// 2-row frame. Each vector gives the inputs for one clock edge and the
// outputs expected just after it.
// ---------------------------------------------------------------------------
module tb_pixel_row_assembler;

   localparam int unsigned NB = 4;
   localparam int unsigned NR = 2;
   localparam int unsigned AB = 1;

   typedef struct {
      logic          fs;
      logic          pv;
      logic          pd;
      logic          rdy;
      logic          we;
      logic          busy;
      logic          done;
      logic [NB-1:0] data;
      logic [AB-1:0] addr;
   } vec_t;

   logic Clock;
   logic Reset;
   logic Tick;

   int   n_cmp;
   int   n_err;
   int   we_edges;
   vec_t tbl[$];

   pixel_row_assembler_if #(.NrOfBits(NB), .RowAddrBits(AB)) bus ();

   pixel_row_assembler #(
      .NrOfBits    (NB),
      .NrOfRows    (NR),
      .RowAddrBits (AB)
   ) dut (
      .Clock (Clock),
      .Reset (Reset),
      .Tick  (Tick),
      .bus   (bus)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic fs, input logic pv, input logic pd,
                               input logic rdy, input logic we, input logic busy,
                               input logic done, input logic [NB-1:0] data,
                               input logic [AB-1:0] addr);
      vec_t v;
      v.fs = fs; v.pv = pv; v.pd = pd;
      v.rdy = rdy; v.we = we; v.busy = busy; v.done = done;
      v.data = data; v.addr = addr;
      return v;
   endfunction

   function automatic logic [8:0] observed();
      return {bus.PixelReady, bus.RowWe, bus.Busy, bus.FrameDone, bus.RowData, bus.RowAddr};
   endfunction

   function automatic logic [8:0] expected(input vec_t v);
      return {v.rdy, v.we, v.busy, v.done, v.data, v.addr};
   endfunction

   task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got rdy/we/busy/done/data/addr=%b required %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, settle just after the edge.
   task automatic drive(input logic tk, input logic fs, input logic pv, input logic pd);
      Tick           = tk;
      bus.FrameStart = fs;
      bus.PixelValid = pv;
      bus.PixelData  = pd;
      if (tk && bus.RowWe) we_edges++;
      @(posedge Clock);
      #1;
   endtask

   // Full frame: rows 1011 and 0110; pixels offered in WRITE/DONE/IDLE ignored.
   task automatic load_frame();
      tbl.delete();
      tbl.push_back(mk(1,0,0, 1,0,1,0, 4'b0000, 1'b0));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b1000, 1'b0));
      tbl.push_back(mk(0,1,0, 1,0,1,0, 4'b1000, 1'b0));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b1010, 1'b0));
      tbl.push_back(mk(0,1,1, 0,1,1,0, 4'b1011, 1'b0));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b0000, 1'b1));
      tbl.push_back(mk(0,1,0, 1,0,1,0, 4'b0000, 1'b1));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b0100, 1'b1));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b0110, 1'b1));
      tbl.push_back(mk(0,1,0, 0,1,1,0, 4'b0110, 1'b1));
      tbl.push_back(mk(0,0,0, 0,0,0,1, 4'b0110, 1'b1));
      tbl.push_back(mk(0,1,1, 0,0,0,0, 4'b0110, 1'b1));
      tbl.push_back(mk(0,1,1, 0,0,0,0, 4'b0110, 1'b1));
   endtask

   // Abort after 2 pixels of row 1, fresh frame 0101/1111, then restart from DONE.
   task automatic load_abort();
      tbl.delete();
      tbl.push_back(mk(1,0,0, 1,0,1,0, 4'b0000, 1'b0));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b1000, 1'b0));
      tbl.push_back(mk(0,1,0, 1,0,1,0, 4'b1000, 1'b0));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b1010, 1'b0));
      tbl.push_back(mk(0,1,1, 0,1,1,0, 4'b1011, 1'b0));
      tbl.push_back(mk(0,0,0, 1,0,1,0, 4'b0000, 1'b1));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b1000, 1'b1));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b1100, 1'b1));
      tbl.push_back(mk(1,1,1, 1,0,1,0, 4'b0000, 1'b0));
      tbl.push_back(mk(0,1,0, 1,0,1,0, 4'b0000, 1'b0));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b0100, 1'b0));
      tbl.push_back(mk(0,1,0, 1,0,1,0, 4'b0100, 1'b0));
      tbl.push_back(mk(0,1,1, 0,1,1,0, 4'b0101, 1'b0));
      tbl.push_back(mk(0,0,0, 1,0,1,0, 4'b0000, 1'b1));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b1000, 1'b1));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b1100, 1'b1));
      tbl.push_back(mk(0,1,1, 1,0,1,0, 4'b1110, 1'b1));
      tbl.push_back(mk(0,1,1, 0,1,1,0, 4'b1111, 1'b1));
      tbl.push_back(mk(0,0,0, 0,0,0,1, 4'b1111, 1'b1));
      tbl.push_back(mk(1,0,0, 1,0,1,0, 4'b0000, 1'b0));
   endtask

   // mode 0: plain; 1: Tick=0 cycle after each vector; 2: 3-cycle PixelValid gaps.
   task automatic run_table(input string tag, input int mode, input int exp_we);
      vec_t v;
      we_edges = 0;
      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         drive(1'b1, v.fs, v.pv, v.pd);
         check($sformatf("%s vec %0d", tag, i), observed(), expected(v));
         if (mode == 1) begin
            drive(1'b0, logic'(i % 2), 1'b1, logic'((i + 1) % 2));
            check($sformatf("%s hold %0d", tag, i), observed(), expected(v));
         end else if (mode == 2 && v.rdy) begin
            for (int g = 0; g < 3; g++) begin
               drive(1'b1, 1'b0, 1'b0, 1'b1);
            end
            check($sformatf("%s gap %0d", tag, i), observed(), expected(v));
         end
      end
      check_int($sformatf("%s RowWe&Tick edges", tag), we_edges, exp_we);
   endtask

   task automatic feed_row(input logic [NB-1:0] row);
      for (int b = NB - 1; b >= 0; b--) begin
         drive(1'b1, 1'b0, 1'b1, row[b]);
      end
   endtask

   initial begin
      n_cmp          = 0;
      n_err          = 0;
      we_edges       = 0;
      Reset          = 1'b1;
      Tick           = 1'b0;
      bus.FrameStart = 1'b0;
      bus.PixelValid = 1'b0;
      bus.PixelData  = 1'b0;

      // Reset then idle: everything zero, PixelValid ignored without FrameStart.
      repeat (2) @(posedge Clock);
      #1;
      check("reset state", observed(), 9'b0);
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b1, 1'b1);
         check($sformatf("idle %0d", i), observed(), 9'b0);
      end

      load_frame();
      run_table("frame", 0, 2);
      run_table("tick", 1, 2);
      run_table("gaps", 2, 2);

      // One write before the abort plus two for the fresh frame.
      load_abort();
      run_table("abort", 0, 3);

      // Async reset while writing row 1.
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      feed_row(4'b1011);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      feed_row(4'b0110);
      check("pre-reset write", observed(), {1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 1'b1});
      #2;
      Reset = 1'b1;
      #1;
      check("async reset mid-write", observed(), 9'b0);
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      drive(1'b1, 1'b0, 1'b1, 1'b1);
      check("idle after reset", observed(), 9'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      check("restart after reset", observed(), {1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_pixel_row_assembler
